// File: rtl/riscv_wb_ram_if.sv
// rtl/riscv_wb_ram_if.sv - Wishbone B4 pipelined bus bundle between the LSU master and riscv_wb_ram
interface riscv_wb_ram_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [29:0] wb_addr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_data_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i,
        input  wb_data_o, wb_ack_o, wb_err_o, wb_stall_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i,
        output wb_data_o, wb_ack_o, wb_err_o, wb_stall_o
    );
endinterface

// File: rtl/riscv_wb_ram.sv
// rtl/riscv_wb_ram.sv - Wishbone B4 pipelined RAM slave, fixed latency; RISCV_WB_RAM_ERR_EN flags out-of-range addresses
module riscv_wb_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    riscv_wb_ram_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [3:0]    req_sel;
    logic [31:0]   req_data;
    logic          req_bad;
    logic          ack_q;
    logic [31:0]   data_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          in_bad;
    logic [AW-1:0] cur_addr;
    logic          cur_we;
    logic [3:0]    cur_sel;
    logic [31:0]   cur_data;
    logic          cur_bad;

`ifdef RISCV_WB_RAM_ERR_EN
    logic err_q;
    assign in_bad = |bus.wb_addr_i[29:AW];
`else
    assign in_bad = 1'b0;
`endif

    // Stall is a pure decode of the state register, so it never depends combinationally on the bus
    assign accept = bus.wb_cyc_i & bus.wb_stb_i & (state != S_WAIT);

    // Request being completed: live bus fields for a zero-wait accept, latched fields after a wait
    always_comb begin
        cur_addr = req_addr;
        cur_we   = req_we;
        cur_sel  = req_sel;
        cur_data = req_data;
        cur_bad  = req_bad;
        if (state != S_WAIT) begin
            cur_addr = bus.wb_addr_i[AW-1:0];
            cur_we   = bus.wb_we_i;
            cur_sel  = bus.wb_sel_i;
            cur_data = bus.wb_data_i;
            cur_bad  = in_bad;
        end
    end

    // Next-state logic; dropping cyc during a wait abandons the request
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_WAIT: begin
                if (!bus.wb_cyc_i)       state_next = S_IDLE;
                else if (wait_cnt == '0) state_next = S_RESP;
                else                     state_next = S_WAIT;
            end
            default: begin
                if (accept) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
        endcase
    end

    assign enter_resp = (state_next == S_RESP);

    // State, request capture, wait counter, ack and read data registers
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            req_addr <= '0;
            req_we   <= 1'b0;
            req_sel  <= '0;
            req_data <= '0;
            req_bad  <= 1'b0;
            ack_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state <= state_next;
            ack_q <= enter_resp & ~cur_bad;
            if (accept) begin
                req_addr <= bus.wb_addr_i[AW-1:0];
                req_we   <= bus.wb_we_i;
                req_sel  <= bus.wb_sel_i;
                req_data <= bus.wb_data_i;
                req_bad  <= in_bad;
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp && !cur_we && !cur_bad) begin
                data_q <= mem[cur_addr];
            end
        end
    end

    // Byte-lane commit on the edge entering RESP; reset suppresses it but leaves contents intact
    always_ff @(posedge clk_i) begin
        if (reset_ni && enter_resp && cur_we && !cur_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_sel[i]) mem[cur_addr][8*i +: 8] <= cur_data[8*i +: 8];
            end
        end
    end

`ifdef RISCV_WB_RAM_ERR_EN
    // Out-of-range requests complete with err in the slot where ack would have been
    always_ff @(posedge clk_i) begin
        if (!reset_ni) err_q <= 1'b0;
        else           err_q <= enter_resp & cur_bad;
    end
    assign bus.wb_err_o = err_q;
`else
    assign bus.wb_err_o = 1'b0;
`endif

    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_data_o  = data_q;
    assign bus.wb_stall_o = (state == S_WAIT);
endmodule

// File: tb/tb_riscv_wb_ram.sv
// tb/tb_riscv_wb_ram.sv - scoreboard testbench for riscv_wb_ram at 0, 1 and 3 wait states
module tb_riscv_wb_ram;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    riscv_wb_ram_if bus0 ();
    riscv_wb_ram_if bus1 ();
    riscv_wb_ram_if bus3 ();

    riscv_wb_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (.clk_i(clk), .reset_ni(reset_n), .bus(bus0));
    riscv_wb_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (.clk_i(clk), .reset_ni(reset_n), .bus(bus1));
    riscv_wb_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (.clk_i(clk), .reset_ni(reset_n), .bus(bus3));

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_chk  = 0;
    int   n_fail = 0;
    virtual riscv_wb_ram_if mon;

    // Scoreboard: every response on the monitored bus is matched against the oldest expectation
    always @(negedge clk) begin
        if (mon.wb_ack_o && mon.wb_err_o) begin
            n_chk++; n_fail++;
            $display("FAIL ack_err_both: ack=1 err=1, required at most one");
        end else if (mon.wb_ack_o || mon.wb_err_o) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b with nothing outstanding", mon.wb_ack_o, mon.wb_err_o);
            end else begin
                e_mon = sb.pop_front();
                if (mon.wb_err_o !== e_mon.err || mon.wb_ack_o !== !e_mon.err ||
                    (e_mon.chk && mon.wb_data_o !== e_mon.data)) begin
                    n_fail++;
                    $display("FAIL resp: ack=%0b err=%0b data=%08h, required err=%0b data=%08h",
                             mon.wb_ack_o, mon.wb_err_o, mon.wb_data_o, e_mon.err, e_mon.data);
                end
            end
        end
    end

    task automatic push(input logic err, input logic chk, input logic [31:0] data);
        exp_t e;
        e.err = err; e.chk = chk; e.data = data;
        sb.push_back(e);
    endtask

    // Issue one request and hold it until the slave stops stalling; called just after a posedge
    task automatic req(virtual riscv_wb_ram_if v, input logic we, input logic [29:0] addr,
                       input logic [3:0] sel, input logic [31:0] data);
        int n = 0;
        v.wb_cyc_i = 1'b1; v.wb_stb_i = 1'b1; v.wb_we_i = we;
        v.wb_addr_i = addr; v.wb_sel_i = sel; v.wb_data_i = data;
        @(negedge clk);
        while (v.wb_stall_o && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) begin
            n_chk++; n_fail++;
            $display("FAIL req_stall_timeout: stall=%0b after 50 cycles, required 0", v.wb_stall_o);
        end
        @(posedge clk); #1;
        v.wb_stb_i = 1'b0;
    endtask

    task automatic drain(virtual riscv_wb_ram_if v);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk); n++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        v.wb_cyc_i = 1'b0; v.wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (bus1.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b, required 0", bus1.wb_ack_o); end
        n_chk++; if (bus1.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, required 0", bus1.wb_err_o); end
        n_chk++; if (bus1.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b, required 0", bus1.wb_stall_o); end
        n_chk++; if (bus1.wb_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %08h, required 0", bus1.wb_data_o); end
        n_chk++; if (bus3.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall3: got %0b, required 0", bus3.wb_stall_o); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        mon = bus1;
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h4, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        n_chk++; if (bus1.wb_stall_o !== 1'b1) begin n_fail++; $display("FAIL lat_stall_c1: got %0b, required 1", bus1.wb_stall_o); end
        n_chk++; if (bus1.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL lat_ack_c1: got %0b, required 0", bus1.wb_ack_o); end
        @(negedge clk);
        n_chk++; if (bus1.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL lat_ack_c2: got %0b, required 1", bus1.wb_ack_o); end
        n_chk++; if (bus1.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL lat_stall_c2: got %0b, required 0", bus1.wb_stall_o); end
        drain(bus1);
        push(1'b0, 1'b1, 32'hDEADBEEF);
        req(bus1, 1'b0, 30'h4, 4'hF, 32'h0);
        drain(bus1);
    endtask

    task automatic test_byte_lanes();
        mon = bus1;
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h8, 4'hF, 32'h11223344);
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h8, 4'b0100, 32'h00AA0000);
        push(1'b0, 1'b1, 32'h11AA3344);
        req(bus1, 1'b0, 30'h8, 4'hF, 32'h0);
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h8, 4'h0, 32'hFFFFFFFF);
        push(1'b0, 1'b1, 32'h11AA3344);
        req(bus1, 1'b0, 30'h8, 4'hF, 32'h0);
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h9, 4'b1001, 32'hA1B2C3D4);
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h9, 4'b0110, 32'h55667788);
        push(1'b0, 1'b1, 32'hA16677D4);
        req(bus1, 1'b0, 30'h9, 4'hF, 32'h0);
        drain(bus1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        mon = bus0;
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom;
            push(1'b0, 1'b0, 32'h0);
            req(bus0, 1'b1, 30'(i), 4'hF, vals[i]);
        end
        drain(bus0);
        bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1; bus0.wb_we_i = 1'b0;
        bus0.wb_sel_i = 4'hF; bus0.wb_addr_i = 30'h0;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b1, vals[i]);
            @(negedge clk);
            n_chk++; if (bus0.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_c%0d: got 1, required 0", i); end
            if (i > 0) begin
                n_chk++; if (bus0.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_c%0d: got 0, required 1", i); end
            end
            @(posedge clk); #1;
            if (i < 3) bus0.wb_addr_i = 30'(i + 1);
            else       bus0.wb_stb_i = 1'b0;
        end
        @(negedge clk);
        n_chk++; if (bus0.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_c4: got 0, required 1"); end
        drain(bus0);
        push(1'b0, 1'b0, 32'h0);
        req(bus0, 1'b1, 30'h5, 4'hF, 32'h0F1E2D3C);
        push(1'b0, 1'b1, 32'h0F1E2D3C);
        req(bus0, 1'b0, 30'h5, 4'hF, 32'h0);
        drain(bus0);
    endtask

    task automatic test_abort();
        mon = bus3;
        push(1'b0, 1'b0, 32'h0);
        req(bus3, 1'b1, 30'h10, 4'hF, 32'h12345678);
        drain(bus3);
        req(bus3, 1'b1, 30'h10, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        n_chk++; if (bus3.wb_stall_o !== 1'b1) begin n_fail++; $display("FAIL abort_stall_c1: got 0, required 1"); end
        @(posedge clk); #1;
        bus3.wb_cyc_i = 1'b0;
        @(negedge clk);
        n_chk++; if (bus3.wb_stall_o !== 1'b1) begin n_fail++; $display("FAIL abort_stall_c2: got 0, required 1"); end
        @(negedge clk);
        n_chk++; if (bus3.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL abort_stall_c3: got 1, required 0"); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus3.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL abort_ack_c%0d: got 1, required 0", i + 3); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        push(1'b0, 1'b1, 32'h12345678);
        req(bus3, 1'b0, 30'h10, 4'hF, 32'h0);
        drain(bus3);
    endtask

    task automatic test_reset_wait();
        mon = bus1;
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h20, 4'hF, 32'hA5A5A5A5);
        push(1'b0, 1'b1, 32'hA5A5A5A5);
        req(bus1, 1'b0, 30'h20, 4'hF, 32'h0);
        drain(bus1);
        req(bus1, 1'b1, 30'h20, 4'hF, 32'h5A5A5A5A);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus1.wb_cyc_i = 1'b0;
        @(negedge clk);
        n_chk++; if (bus1.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rstw_ack: got %0b, required 0", bus1.wb_ack_o); end
        n_chk++; if (bus1.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL rstw_stall: got %0b, required 0", bus1.wb_stall_o); end
        n_chk++; if (bus1.wb_data_o !== 32'h0) begin n_fail++; $display("FAIL rstw_data: got %08h, required 0", bus1.wb_data_o); end
        n_chk++; if (bus1.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL rstw_err: got %0b, required 0", bus1.wb_err_o); end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        push(1'b0, 1'b1, 32'hA5A5A5A5);
        req(bus1, 1'b0, 30'h20, 4'hF, 32'h0);
        drain(bus1);
    endtask

    task automatic test_addr_high();
        mon = bus1;
        push(1'b0, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h0, 4'hF, 32'h0BADC0DE);
        push(1'b0, 1'b1, 32'h0BADC0DE);
        req(bus1, 1'b0, 30'h0, 4'hF, 32'h0);
`ifdef RISCV_WB_RAM_ERR_EN
        push(1'b1, 1'b0, 32'h0);
        req(bus1, 1'b0, 30'h400, 4'hF, 32'h0);
        push(1'b1, 1'b0, 32'h0);
        req(bus1, 1'b1, 30'h400, 4'hF, 32'hFFFFFFFF);
        push(1'b0, 1'b1, 32'h0BADC0DE);
        req(bus1, 1'b0, 30'h0, 4'hF, 32'h0);
`else
        push(1'b0, 1'b1, 32'h0BADC0DE);
        req(bus1, 1'b0, 30'h400, 4'hF, 32'h0);
`endif
        drain(bus1);
        n_chk++; if (bus1.wb_data_o !== 32'h0BADC0DE) begin n_fail++; $display("FAIL high_data_hold: got %08h, required 0badc0de", bus1.wb_data_o); end
    endtask

    initial begin
        mon = bus1;
        bus0.wb_cyc_i = 0; bus0.wb_stb_i = 0; bus0.wb_we_i = 0; bus0.wb_addr_i = 0; bus0.wb_sel_i = 0; bus0.wb_data_i = 0;
        bus1.wb_cyc_i = 0; bus1.wb_stb_i = 0; bus1.wb_we_i = 0; bus1.wb_addr_i = 0; bus1.wb_sel_i = 0; bus1.wb_data_i = 0;
        bus3.wb_cyc_i = 0; bus3.wb_stb_i = 0; bus3.wb_we_i = 0; bus3.wb_addr_i = 0; bus3.wb_sel_i = 0; bus3.wb_data_i = 0;
        test_reset();
        test_latency();
        test_byte_lanes();
        test_back_to_back();
        test_abort();
        test_reset_wait();
        test_addr_high();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
